uart_frame_receiver: RTL
========================

// Module: uart_frame_receiver
// PURPOSE
//  Next-generation UART frame receiver. Consumes a byte stream from uart_rx,
//  hunts for the 32-bit magic header, collects a parametrised payload, checks
//  the trailing CRC-16 and presents good payloads on a valid/ready handshake.
//  Sits between uart_rx and the motor-command / loopback logic.
// PARAMETERS
//  PAYLOAD_BYTES   2             payload length in bytes, 1..32; frame = 4 + PAYLOAD_BYTES + 2
//  MAGIC           32'hDABBAD00  header, transmitted MSB byte first
//  CRC_INIT        16'hFFFF      CRC seed at start of each frame
//  TIMEOUT_CYCLES  16000         inter-byte timeout in CLK cycles (FRAME_RX_TIMEOUT_EN only)
// PORTS
//  CLK            in   1                 system clock (16 MHz)
//  RST            in   1                 synchronous, active-high reset
//  rx_valid       in   1                 one-cycle strobe, rx_data holds a new byte
//  rx_data        in   8                 received byte
//  frame_valid    out  1                 good payload available
//  frame_ready    in   1                 consumer accepts payload when frame_valid & frame_ready
//  frame_payload  out  8*PAYLOAD_BYTES   payload; first received byte in MSBs
//  crc_err_count  out  16                saturating count of frames failing CRC
//  overrun_count  out  16                saturating count of good frames dropped (consumer busy)
//  busy           out  1                 parser is past HUNT (mid-frame)
// BEHAVIOUR
//  Reset: state HUNT, frame_valid 0, frame_payload 0, both counters 0, busy 0, CRC = CRC_INIT.
//  All state advances only on cycles with rx_valid=1; rx_valid=0 cycles hold state.
//  CRC: poly x^16+x^15+x^2+1 (0x8005), no reflection, no final XOR, one byte per cycle MSB
//   first, over header + payload in arrival order. CRC on the wire: high byte, then low.
//  States:
//   HUNT    - hdr_idx 0..3. Byte == MAGIC byte[hdr_idx]: idx+1, CRC updated; idx 3 match -> PAYLOAD.
//             Mismatch: CRC reset; the mismatching byte is re-tested against MAGIC[31:24]
//             (match -> idx 1, CRC = update(CRC_INIT, byte); else idx 0).
//   PAYLOAD - store byte at index pay_idx, CRC update; after PAYLOAD_BYTES bytes -> CRC_HI.
//   CRC_HI  - latch received high byte -> CRC_LO.
//   CRC_LO  - compare {hi, byte} to computed CRC -> HUNT (idx 0, CRC_INIT) in all cases.
//  Latency: frame_valid rises the cycle after the CRC_LO byte's rx_valid.
//  Result on CRC_LO:
//   - mismatch: crc_err_count+1 (saturate at 16'hFFFF); output unchanged.
//   - match, frame_valid=0, or frame_valid & frame_ready same cycle: load payload, frame_valid=1.
//   - match, frame_valid & !frame_ready: new frame dropped, old payload held, overrun_count+1 (sat).
//  Handshake: frame_payload stable while frame_valid=1; frame_valid clears the cycle after
//   frame_valid & frame_ready unless a new good frame loads in that same cycle.
//  Payload shadow buffer is internal; frame_payload changes only on a load.
//  RST mid-frame: abort immediately to reset values; partial frame discarded, counters cleared.
//  busy = (state != HUNT) || (hdr_idx != 0).
// CONFIGURATION
//  FRAME_RX_TIMEOUT_EN defined: cycle counter clears on each rx_valid; if busy and counter
//   reaches TIMEOUT_CYCLES, parser returns to HUNT (idx 0, CRC_INIT), no counter increments.
//  Undefined: no timer logic; resync only via header mismatch. TIMEOUT_CYCLES ignored.
// TESTING
//  1 DA BB AD 00 12 34 + golden CRC, frame_ready=1 -> frame_valid 1 cycle, payload 16'h1234.
//  2 Same frame, last CRC byte XOR 8'h01 -> no frame_valid, crc_err_count 0->1.
//  3 Stream DA DA BB AD 00 56 78 + CRC -> resync on 2nd DA, payload 16'h5678 delivered.
//  4 Two good frames, frame_ready=0 -> first payload held, overrun_count=1; ready=1 -> valid drops.
//  5 RST after DA BB AD 00 12 -> busy 0, frame_valid 0; following good frame received normally.
//  6 (TIMEOUT_EN, TIMEOUT_CYCLES=100) DA BB, 150 idle cycles, AD 00 .. -> no frame; busy 0 at cycle 100.

Source files
------------

// File: rtl/uart_frame_receiver_if.sv
// Byte-stream input and payload valid/ready output bundle for uart_frame_receiver.
// master = byte source / payload consumer side, slave = the receiver.
interface uart_frame_receiver_if #(
  parameter int unsigned PAYLOAD_BYTES = 2
);
  logic                       rx_valid;
  logic [7:0]                 rx_data;
  logic                       frame_valid;
  logic                       frame_ready;
  logic [8*PAYLOAD_BYTES-1:0] frame_payload;
  logic [15:0]                crc_err_count;
  logic [15:0]                overrun_count;
  logic                       busy;

  modport master (
    output rx_valid, rx_data, frame_ready,
    input  frame_valid, frame_payload, crc_err_count, overrun_count, busy
  );

  modport slave (
    input  rx_valid, rx_data, frame_ready,
    output frame_valid, frame_payload, crc_err_count, overrun_count, busy
  );
endinterface

// File: rtl/uart_frame_receiver.sv
// UART frame receiver: magic-header hunt, payload capture, CRC-16 (0x8005) check, valid/ready output.
// Optional inter-byte timeout enabled by defining FRAME_RX_TIMEOUT_EN.
module uart_frame_receiver #(
  parameter int unsigned PAYLOAD_BYTES = 2,
  parameter logic [31:0] MAGIC         = 32'hDABBAD00,
  parameter logic [15:0] CRC_INIT      = 16'hFFFF
`ifdef FRAME_RX_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 16000
`endif
) (
  input logic                 CLK,
  input logic                 RST,
  uart_frame_receiver_if.slave bus
);

  localparam int unsigned PW       = 8 * PAYLOAD_BYTES;
  localparam int unsigned IDX_W    = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES - 1);

  typedef enum logic [1:0] {HUNT, PAYLOAD, CRC_HI, CRC_LO} state_t;

  state_t           state;
  logic [1:0]       hdr_idx;
  logic [IDX_W-1:0] pay_idx;
  logic [15:0]      crc;
  logic [7:0]       crc_hi;
  logic [PW-1:0]    shadow;
  logic [PW-1:0]    payload;
  logic             frame_valid;
  logic [15:0]      crc_err_count;
  logic [15:0]      overrun_count;
  logic             busy;
  logic [7:0]       magic_byte_c;

`ifdef FRAME_RX_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer;
`endif

  // One byte of CRC-16, polynomial 0x8005, MSB first, no reflection.
  function automatic logic [15:0] crc16_update(input logic [15:0] c_in, input logic [7:0] d);
    logic [15:0] c;
    c = c_in ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ 16'h8005) : (c << 1);
    end
    return c;
  endfunction

  always_comb begin
    magic_byte_c = MAGIC[31:24];
    case (hdr_idx)
      2'd1:    magic_byte_c = MAGIC[23:16];
      2'd2:    magic_byte_c = MAGIC[15:8];
      2'd3:    magic_byte_c = MAGIC[7:0];
      default: magic_byte_c = MAGIC[31:24];
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= HUNT;
      hdr_idx       <= 2'd0;
      pay_idx       <= '0;
      crc           <= CRC_INIT;
      crc_hi        <= 8'h00;
      shadow        <= '0;
      payload       <= '0;
      frame_valid   <= 1'b0;
      crc_err_count <= 16'h0000;
      overrun_count <= 16'h0000;
      busy          <= 1'b0;
`ifdef FRAME_RX_TIMEOUT_EN
      timer         <= '0;
`endif
    end else begin
      if (frame_valid && bus.frame_ready) frame_valid <= 1'b0;
`ifdef FRAME_RX_TIMEOUT_EN
      if (bus.rx_valid)                       timer <= '0;
      else if (timer != TW'(TIMEOUT_CYCLES))  timer <= timer + TW'(1);
`endif
      if (bus.rx_valid) begin
        case (state)
          HUNT: begin
            if (bus.rx_data == magic_byte_c) begin
              crc  <= crc16_update(crc, bus.rx_data);
              busy <= 1'b1;
              if (hdr_idx == 2'd3) begin
                state   <= PAYLOAD;
                hdr_idx <= 2'd0;
                pay_idx <= '0;
              end else begin
                hdr_idx <= hdr_idx + 2'd1;
              end
            end else if (bus.rx_data == MAGIC[31:24]) begin
              // Mismatching byte may itself start a new header.
              hdr_idx <= 2'd1;
              crc     <= crc16_update(CRC_INIT, bus.rx_data);
              busy    <= 1'b1;
            end else begin
              hdr_idx <= 2'd0;
              crc     <= CRC_INIT;
              busy    <= 1'b0;
            end
          end
          PAYLOAD: begin
            shadow[PW - 8 - 8 * int'(pay_idx) +: 8] <= bus.rx_data;
            crc <= crc16_update(crc, bus.rx_data);
            if (pay_idx == LAST_IDX) state   <= CRC_HI;
            else                     pay_idx <= pay_idx + IDX_W'(1);
          end
          CRC_HI: begin
            crc_hi <= bus.rx_data;
            state  <= CRC_LO;
          end
          CRC_LO: begin
            state   <= HUNT;
            hdr_idx <= 2'd0;
            crc     <= CRC_INIT;
            busy    <= 1'b0;
            if ({crc_hi, bus.rx_data} != crc) begin
              if (crc_err_count != 16'hFFFF) crc_err_count <= crc_err_count + 16'd1;
            end else if (!frame_valid || bus.frame_ready) begin
              payload     <= shadow;
              frame_valid <= 1'b1;
            end else if (overrun_count != 16'hFFFF) begin
              overrun_count <= overrun_count + 16'd1;
            end
          end
          default: state <= HUNT;
        endcase
      end
`ifdef FRAME_RX_TIMEOUT_EN
      else if (busy && (timer == TW'(TIMEOUT_CYCLES - 1))) begin
        state   <= HUNT;
        hdr_idx <= 2'd0;
        crc     <= CRC_INIT;
        busy    <= 1'b0;
      end
`endif
    end
  end

  assign bus.frame_valid   = frame_valid;
  assign bus.frame_payload = payload;
  assign bus.crc_err_count = crc_err_count;
  assign bus.overrun_count = overrun_count;
  assign bus.busy          = busy;

endmodule
